// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encoding and drain-counter width for the hazard controller.
package hazard_pkg;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating stall/flush cycle counters (built only with HAZARD_PERF_CNT_EN).
import hazard_pkg::*;
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        idex_flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
);
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= (pc_stall && stall_q != '1) ? stall_q + 32'd1 : stall_q;
      flush_q <= (idex_flush && flush_q != '1) ? flush_q + 32'd1 : flush_q;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, redirect, eret drain and memory wait.
// Performance counters are present only when HAZARD_PERF_CNT_EN is defined.
import hazard_pkg::*;
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_redirect,
  input  logic        ex_eret,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
);
  state_e state_q, state_d, eff;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ret_q, ret_d;
  logic load_use, busy, drain, eret, redir, lu;
  assign load_use = ex_load && ex_rd != 5'd0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  // Leaving MEMWAIT resolves to the state it interrupted within the same cycle.
  always_comb begin
    eff = (state_q == MEMWAIT) ? (ret_q ? DRAIN : RUN) : state_q;
    busy = !rst && mem_busy;
    drain = !rst && !mem_busy && eff == DRAIN;
    eret = !rst && !mem_busy && eff == RUN && ex_eret;
    redir = !rst && !mem_busy && eff == RUN && !ex_eret && ex_redirect;
    lu = !rst && !mem_busy && eff == RUN && !ex_eret && !ex_redirect && load_use;
    state_d = busy ? MEMWAIT : eret ? DRAIN : (drain && cnt_q > CNT_W'(1)) ? DRAIN : RUN;
    cnt_d = eret ? CNT_W'(DRAIN_CYCLES) : (drain && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    ret_d = busy ? (state_q == DRAIN || (state_q == MEMWAIT && ret_q)) : 1'b0;
  end
  assign pc_stall    = busy || lu;
  assign ifid_stall  = busy || lu;
  assign ifid_flush  = drain || eret || redir;
  assign idex_stall  = busy;
  assign idex_flush  = drain || eret || redir || lu;
  assign exmem_stall = busy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      ret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ret_q <= ret_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .idex_flush(idex_flush),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_hazard_ctrl;
  typedef struct {logic [5:0] v; string n;} exp_t;
  localparam logic [5:0] O = 6'b000000, MB = 6'b110101, FL = 6'b001010, LU = 6'b110010;
  logic clk = 0, rst = 1;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_load = 0, ex_redirect = 0, ex_eret = 0, mem_busy = 0;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
  logic [31:0] stall_cycles, flush_cycles;
  exp_t q[$];
  exp_t me;
  int tests = 0, fails = 0;
  int unsigned ms = 0, mf = 0;
  hazard_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_load(ex_load), .ex_redirect(ex_redirect),
    .ex_eret(ex_eret), .mem_busy(mem_busy), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );
  always #5 clk = ~clk;
  task automatic step(input string nm, input logic [5:0] ev, input logic r = 0, b = 0, e = 0,
                      x = 0, l = 0, input logic [4:0] rd = 0, r1 = 0, r2 = 0,
                      input logic u1 = 0, u2 = 0);
    exp_t t;
    @(negedge clk);
    rst = r; mem_busy = b; ex_eret = e; ex_redirect = x; ex_load = l;
    ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    t.v = ev; t.n = nm;
    q.push_back(t);
    if (r) begin ms = 0; mf = 0; end
    else begin ms += ev[5]; mf += ev[1]; end
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      me = q.pop_front();
      tests++;
      if ({pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall} !== me.v) begin
        fails++;
        $display("FAIL %s got=%b exp=%b (pc,ifs,iff,ids,idf,exs)", me.n,
                 {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}, me.v);
      end
    end
  end
  initial begin
    step("reset0", O, 1);
    step("reset1", O, 1, 0, 1, 1, 1, 5, 5, 5, 1, 1);
    step("idle", O);
    step("lu_rs2", LU, 0, 0, 0, 0, 1, 5, 0, 5, 0, 1);
    step("lu_after", O);
    step("lu_rs1", LU, 0, 0, 0, 0, 1, 7, 7, 0, 1, 0);
    step("lu_nouse", O, 0, 0, 0, 0, 1, 7, 7, 7, 0, 0);
    step("lu_x0", O, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    step("noload", O, 0, 0, 0, 0, 0, 5, 5, 5, 1, 1);
    step("redir_lu", FL, 0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
    step("redir_once", O);
    step("eret", FL, 0, 0, 1, 0, 1, 5, 5, 0, 1, 0);
    step("drain1", FL, 0, 0, 0, 0, 1, 5, 5, 0, 1, 0);
    step("drain2", FL);
    step("drain_done", O);
    step("eret_b", FL, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("drain_busy", MB, 0, 1);
    step("drain_res1", FL);
    step("drain_res2", FL);
    step("drain_b_done", O);
    step("busy_lu", MB, 0, 1, 0, 0, 1, 3, 3, 0, 1, 0);
    step("memwait_lu", LU, 0, 0, 0, 0, 1, 3, 3, 0, 1, 0);
    step("busy_run", MB, 0, 1, 1, 1);
    step("memwait_eret", FL, 0, 0, 1);
    step("drain_c1", FL);
    step("drain_c2", FL);
    step("drain_c_done", O);
    step("eret_r", FL, 0, 0, 1);
    step("drain_r", FL);
    step("rst_mid", O, 1);
    step("post_rst", O);
    step("post_rst2", O, 0, 0, 0, 0, 0, 9, 9, 0, 1, 0);
    step("post_lu", LU, 0, 0, 0, 0, 1, 9, 9, 0, 1, 0);
    step("idle_end", O);
    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    tests += 2;
    if (stall_cycles !== ms) begin fails++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cycles, ms); end
    if (flush_cycles !== mf) begin fails++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_cycles, mf); end
    dut.u_perf.stall_q = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step("sat_lu", LU, 0, 0, 0, 0, 1, 4, 4, 0, 1, 0);
    step("sat_idle", O);
    @(posedge clk);
    #1;
    tests++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin fails++; $display("FAIL stall_sat got=%h exp=ffffffff", stall_cycles); end
`else
    tests += 2;
    if (stall_cycles !== 32'd0) begin fails++; $display("FAIL stall_tie got=%0d exp=0", stall_cycles); end
    if (flush_cycles !== 32'd0) begin fails++; $display("FAIL flush_tie got=%0d exp=0", flush_cycles); end
`endif
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL drain_q got=%0d exp=0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2, giving the number of extra flush cycles after an eret (range 1..7).
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: source register indices of the instruction in ID.
REQ-005 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 bit each: the ID instruction reads rs1 / rs2.
REQ-006 SHALL have ports ex_rd (input, 5 bits) and ex_load (input, 1 bit): destination register of the instruction in EX, and whether it is a load.
REQ-007 SHALL have port ex_redirect, input, 1 bit: a taken branch, jal or jalr resolved in EX.
REQ-008 SHALL have port ex_eret, input, 1 bit: an eret in EX.
REQ-009 SHALL have port mem_busy, input, 1 bit: data memory not ready this cycle.
REQ-010 SHALL have outputs pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush and exmem_stall, 1 bit each.
  - A stall output holds the register it controls.
  - A flush output loads a bubble into the register it controls.
REQ-011 SHALL have outputs stall_cycles and flush_cycles, 32 bits each: performance counters.

Function
REQ-012 SHALL implement FSM states RUN, MEMWAIT and DRAIN, with a 3-bit drain counter and a 1-bit ret_drain flag.
REQ-013 SHALL apply one fixed priority each cycle: mem_busy, then ex_eret, then ex_redirect, then load-use.
REQ-014 SHALL treat mem_busy=1 in any state as follows:
  - Assert pc_stall, ifid_stall, idex_stall and exmem_stall; drive all flushes 0.
  - Enter MEMWAIT, setting ret_drain=1 if coming from DRAIN.
  - Hold the drain counter.
REQ-015 SHALL, in MEMWAIT with mem_busy=0, return to DRAIN if ret_drain=1, else to RUN, and evaluate the remaining priorities combinationally in that same cycle.
REQ-016 SHALL, on ex_eret=1 in RUN, assert ifid_flush and idex_flush, load the drain counter with DRAIN_CYCLES, and enter DRAIN.
REQ-017 SHALL, in DRAIN, assert ifid_flush and idex_flush, decrement the counter, and return to RUN when the counter reaches 0; pc_stall stays 0.
REQ-018 SHALL, on ex_redirect=1 in RUN (no mem_busy, no eret), assert ifid_flush and idex_flush for that one cycle only.
REQ-019 SHALL detect load-use as: ex_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-020 SHALL, on load-use in RUN, assert pc_stall, ifid_stall and idex_flush for exactly one cycle.
REQ-021 SHALL suppress load-use when ex_redirect or ex_eret is 1 in the same cycle.
REQ-022 SHALL never treat register x0 as a hazard source.
REQ-023 SHALL generate every stall and flush output combinationally from state and inputs, with zero-cycle latency.
REQ-024 SHALL never assert a stall and a flush on the same pipeline register in the same cycle.

Reset
REQ-025 SHALL, while rst=1, force state=RUN, drain counter=0, ret_drain=0, all stall and flush outputs 0, and stall_cycles = flush_cycles = 0.
REQ-026 SHALL abandon any MEMWAIT or DRAIN in progress when rst asserts mid-operation, and resume from RUN afterwards.

Configuration
REQ-027 SHALL, with HAZARD_PERF_CNT_EN defined, count as follows; both counters saturate at 0xFFFFFFFF:
  - stall_cycles increments on each cycle with pc_stall=1.
  - flush_cycles increments on each cycle with idex_flush=1.
REQ-028 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cycles and flush_cycles to 0 and infer no counter registers.

Structure
REQ-029 SHALL place in a shared package hazard_pkg:
  - the state encoding RUN=2'd0, MEMWAIT=2'd1, DRAIN=2'd2;
  - the drain-counter width constant (3).
REQ-030 SHALL implement the counters in one sub-module, hazard_perf_cnt, instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-031 SHALL cover: ex_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_stall=ifid_stall=idex_flush=1 for 1 cycle; next cycle all outputs 0.
REQ-032 SHALL cover: ex_load=1, ex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall and no flush.
REQ-033 SHALL cover: ex_redirect=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_stall=0.
REQ-034 SHALL cover: ex_eret pulse with DRAIN_CYCLES=2 -> ifid_flush=idex_flush=1 for 3 consecutive cycles, then RUN.
REQ-035 SHALL cover: mem_busy=1 for 4 cycles starting in the 2nd DRAIN cycle -> 4 cycles with all four stalls=1 and no flush, then 2 remaining flush cycles.
REQ-036 SHALL cover, with HAZARD_PERF_CNT_EN: stall_cycles preloaded to 0xFFFFFFFE plus 3 stall cycles -> reads 0xFFFFFFFF; asserting rst mid-DRAIN -> all outputs 0 immediately.
